hello_world_qsys_buttons: RTL and testbench
===========================================

HELLO_WORLD_QSYS_BUTTONS -- requirements
Module: hello_world_qsys_buttons

Interface
REQ-001 SHALL have parameter WIDTH, default 5: number of button inputs (1..32).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 50000: number of stable cycles required to accept a level change (1..2^20); used only when debounce is compiled in.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port address, input, 2 bits: Avalon-MM word address.
REQ-006 SHALL have port chipselect, input, 1 bit: slave select.
REQ-007 SHALL have port write_n, input, 1 bit: active-low write strobe.
REQ-008 SHALL have port writedata, input, 32 bits: write data.
REQ-009 SHALL have port in_port, input, WIDTH bits: asynchronous button levels, active-low (idle high).
REQ-010 SHALL have port readdata, output, 32 bits: read data, zero read latency.
REQ-011 SHALL have port irq, output, 1 bit: level interrupt, active-high.

Function
REQ-012 SHALL pass in_port through a two-flop synchronizer (sync1, sync2) before any other use.
REQ-013 SHALL derive the filtered level filt: filt = sync2 when debounce is compiled out; debounced per REQ-026 otherwise.
REQ-014 SHALL register filt into prev each cycle; falling edge for bit i = prev[i] & ~filt[i].
REQ-015 SHALL set edgecapture[i] on the clock edge following a detected falling edge on bit i; the bit stays set until cleared.
REQ-016 Register map: address 0 = data (read filt, zero-extended; writes ignored); address 1 = reserved (reads 0, writes ignored); address 2 = irqmask (R/W, low WIDTH bits); address 3 = edgecapture (read; write-1-to-clear per bit).
REQ-017 A write occurs when chipselect=1 and write_n=0; it takes effect at that clock edge.
REQ-018 When a falling edge and a write-1-to-clear hit the same edgecapture bit in the same cycle, the set SHALL win (no lost event).
REQ-019 readdata SHALL be combinational from address and current register state; unused upper bits read 0; readdata is valid regardless of chipselect.
REQ-020 irq SHALL equal OR over i of (edgecapture[i] & irqmask[i]), combinational from registers.
REQ-021 Latency (debounce off): in_port falling before clock edge k -> data register reads new level after edge k+1; edgecapture bit and irq assert after edge k+2.
REQ-022 Rising edges SHALL NOT set edgecapture.

Reset
REQ-023 On reset=1 at a clock edge: sync1, sync2, filt, prev = all ones; edgecapture = 0; irqmask = 0; debounce counters = 0.
REQ-024 Consequently irq = 0 and readdata at address 0 = all ones (WIDTH bits) immediately after reset; no spurious edge SHALL be captured on reset release while inputs are high.
REQ-025 Reset asserted mid-debounce or with edgecapture pending SHALL discard all pending state without generating irq.

Configuration
REQ-026 Macro BUTTONS_DEBOUNCE_EN defined: per-bit counter counts consecutive cycles with sync2[i] != filt[i]; counter clears whenever sync2[i] == filt[i]; when the count reaches DEBOUNCE_CYCLES, filt[i] takes sync2[i] and the counter clears; counter width = ceil(log2(DEBOUNCE_CYCLES+1)), saturating arithmetic not required.
REQ-027 Macro BUTTONS_DEBOUNCE_EN undefined: no counters instantiated; filt = sync2; DEBOUNCE_CYCLES ignored.

Verification
REQ-028 Reset then read addr 0, 2, 3 -> 0x1F, 0x0, 0x0; irq=0.
REQ-029 Debounce off: in_port 0x1F->0x1E before edge k -> addr 3 reads 0x01 after edge k+2; irqmask=0 so irq=0; write irqmask=0x01 -> irq=1 next cycle.
REQ-030 With edgecapture=0x03, irqmask=0x03, write 0x01 to addr 3 -> edgecapture=0x02, irq stays 1; write 0x02 -> edgecapture=0, irq=0.
REQ-031 Falling edge on bit 2 coincident with write 0x04 to addr 3 -> edgecapture bit 2 remains 1.
REQ-032 Debounce on, DEBOUNCE_CYCLES=4: bit 0 low for 3 cycles then high -> filt unchanged, no capture; low for 6 cycles -> filt[0]=0 after 4 stable cycles, edgecapture=0x01.
REQ-033 Writes to addr 0 and 1 with 0xFFFFFFFF -> no register change; reads of addr 1 return 0.

Source files
------------

// File: rtl/hello_world_qsys_buttons.sv
// Avalon-MM push-button PIO: synchronized active-low inputs, falling-edge capture, masked level IRQ.
// Optional per-bit debounce filter compiled in with `define BUTTONS_DEBOUNCE_EN.
module hello_world_qsys_buttons #(
  parameter int WIDTH           = 5,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_edgecap;
  logic [WIDTH-1:0] r_irqmask;
  logic [WIDTH-1:0] w_filt;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_clr;
  logic             w_wr;

  // Idle level is high, so reset to ones keeps a released reset from looking like a press.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= in_port;
      r_sync2 <= r_sync1;
    end
  end

`ifdef BUTTONS_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0]    r_cnt [WIDTH];
  logic [WIDTH-1:0] r_filt;
  logic             w_unused_ok;

  assign w_unused_ok = ^writedata;

  // A bit's filtered level follows sync2 only after it has disagreed for DEBOUNCE_CYCLES in a row.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_filt <= '1;
      for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (r_sync2[i] == r_filt[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          r_filt[i] <= r_sync2[i];
          r_cnt[i]  <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end

  assign w_filt = r_filt;
`else
  logic w_unused_ok;

  assign w_unused_ok = ^{writedata, DEBOUNCE_CYCLES[0]};
  assign w_filt      = r_sync2;
`endif

  assign w_wr   = chipselect & ~write_n;
  assign w_fall = r_prev & ~w_filt;
  assign w_clr  = (w_wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  // New edges are OR-ed in after the clear so a coincident press is never lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev    <= '1;
      r_edgecap <= '0;
      r_irqmask <= '0;
    end else begin
      r_prev    <= w_filt;
      r_edgecap <= (r_edgecap & ~w_clr) | w_fall;
      if (w_wr && address == 2'd2) r_irqmask <= writedata[WIDTH-1:0];
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata[WIDTH-1:0] = w_filt;
      2'd2:    readdata[WIDTH-1:0] = r_irqmask;
      2'd3:    readdata[WIDTH-1:0] = r_edgecap;
      default: readdata = '0;
    endcase
  end

  assign irq = |(r_edgecap & r_irqmask);

endmodule

// File: tb/tb_hello_world_qsys_buttons.sv
// Scoreboard bench for hello_world_qsys_buttons: expected reads queued at stimulus time, popped at sample time.
module tb_hello_world_qsys_buttons;

  localparam int WIDTH = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [WIDTH-1:0] in_port;
  logic [31:0] readdata;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q [$];

  hello_world_qsys_buttons #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Queue an expected read value, present the address, then pop and compare.
  task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] e;
    exp_q.push_back(exp);
    address = a;
    #1;
    e = exp_q.pop_front();
    check_eq(tag, readdata, e);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    in_port = 5'h1F;
    tick(2);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_port = 5'h1F;
    do_reset();

    rd("rst_data", 2'd0, 32'h1F);
    rd("rst_mask", 2'd2, 32'h0);
    rd("rst_edge", 2'd3, 32'h0);
    check_eq("rst_irq", {31'b0, irq}, 32'h0);
    tick(4);
    rd("rst_noedge", 2'd3, 32'h0);

`ifndef BUTTONS_DEBOUNCE_EN
    // Bit 0 press: data after edge k+1, capture after edge k+2.
    in_port = 5'h1E;
    tick(1);
    rd("lat_data_k", 2'd0, 32'h1F);
    tick(1);
    rd("lat_data_k1", 2'd0, 32'h1E);
    rd("lat_edge_k1", 2'd3, 32'h0);
    tick(1);
    rd("lat_edge_k2", 2'd3, 32'h01);
    check_eq("irq_masked", {31'b0, irq}, 32'h0);
    wr(2'd2, 32'h01);
    check_eq("irq_unmask", {31'b0, irq}, 32'h1);
    rd("mask_rd", 2'd2, 32'h01);

    // Two pending edges, cleared one at a time.
    in_port = 5'h1C;
    tick(3);
    rd("edge_two", 2'd3, 32'h03);
    wr(2'd2, 32'h03);
    wr(2'd3, 32'h01);
    rd("w1c_bit0", 2'd3, 32'h02);
    check_eq("irq_still", {31'b0, irq}, 32'h1);
    wr(2'd3, 32'h02);
    rd("w1c_bit1", 2'd3, 32'h0);
    check_eq("irq_clear", {31'b0, irq}, 32'h0);

    // Bit 2 falling edge lands on the same edge as its write-1-to-clear.
    in_port = 5'h18;
    tick(2);
    address = 2'd3; writedata = 32'h04; chipselect = 1'b1; write_n = 1'b0;
    tick(1);
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    rd("set_wins", 2'd3, 32'h04);
    wr(2'd3, 32'h04);
    rd("clr_after", 2'd3, 32'h0);

    // Releases are rising edges and must not capture.
    in_port = 5'h1F;
    tick(4);
    rd("rise_none", 2'd3, 32'h0);
    rd("rise_data", 2'd0, 32'h1F);
`endif

    // Writes to data and reserved locations change nothing.
    wr(2'd0, 32'hFFFF_FFFF);
    wr(2'd1, 32'hFFFF_FFFF);
    rd("ro_data", 2'd0, 32'h1F);
    rd("rsv_rd", 2'd1, 32'h0);
    rd("ro_edge", 2'd3, 32'h0);

`ifdef BUTTONS_DEBOUNCE_EN
    // Glitch shorter than the debounce window is rejected.
    in_port = 5'h1E;
    tick(3);
    in_port = 5'h1F;
    tick(10);
    rd("db_short_data", 2'd0, 32'h1F);
    rd("db_short_edge", 2'd3, 32'h0);
    // Six cycles low is accepted after four stable cycles.
    in_port = 5'h1E;
    tick(6);
    rd("db_long_data", 2'd0, 32'h1E);
    in_port = 5'h1F;
    tick(10);
    rd("db_long_edge", 2'd3, 32'h01);
    rd("db_back_high", 2'd0, 32'h1F);
    wr(2'd3, 32'h01);
    wr(2'd2, 32'h01);
    in_port = 5'h1E;
    tick(10);
    in_port = 5'h1F;
    tick(10);
    rd("db_pend_edge", 2'd3, 32'h01);
`else
    // Pending capture then reset.
    in_port = 5'h1E;
    tick(3);
    rd("pend_edge", 2'd3, 32'h01);
    check_eq("pend_irq", {31'b0, irq}, 32'h1);
`endif

    // Reset discards pending edges and mask without raising irq.
    do_reset();
    check_eq("rst2_irq", {31'b0, irq}, 32'h0);
    rd("rst2_edge", 2'd3, 32'h0);
    rd("rst2_mask", 2'd2, 32'h0);
    tick(6);
    check_eq("rst2_irq_late", {31'b0, irq}, 32'h0);
    rd("rst2_edge_late", 2'd3, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
